// File: rtl/hammer_hit_detector.sv
// Hammer front end: switch sync/debounce, per-hole arming, strike FSM.
// HAMMER_HIT_ONEHOT_EN: report only the lowest armed lit hole per strike.
module hammer_hit_detector #(
  parameter int NUM_HOLES         = 5,
  parameter int SYNC_STAGES       = 2,
  parameter int SW_DEBOUNCE_TICKS = 1_000_000,
  parameter int COOLDOWN_TICKS    = 20_000_000,
  parameter int CNT_W             = 25
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_HOLES-1:0] swith,
  input  logic [NUM_HOLES-1:0] mole_led,
  input  logic                 hammer_pulse,
  output logic [NUM_HOLES-1:0] hit_vec,
  output logic                 miss_pulse,
  output logic [NUM_HOLES-1:0] armed,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_STRIKE,
    S_COOL
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(SW_DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COOLDOWN_TICKS - 1);

  logic [NUM_HOLES-1:0] r_sync [SYNC_STAGES];
  logic [CNT_W-1:0]     r_db_cnt [NUM_HOLES];
  logic [NUM_HOLES-1:0] r_db;
  logic [NUM_HOLES-1:0] r_db_q;
  logic [NUM_HOLES-1:0] r_armed;
  logic [NUM_HOLES-1:0] r_hit;
  logic                 r_miss;
  logic [CNT_W-1:0]     r_cd_cnt;
  state_t               r_state;

  logic [NUM_HOLES-1:0] w_synced;
  logic [NUM_HOLES-1:0] w_rise;
  logic [NUM_HOLES-1:0] w_lit;
  logic [NUM_HOLES-1:0] w_sel;
  logic [NUM_HOLES-1:0] w_armed_nxt;
  logic                 w_strike;
  logic                 w_open;
  logic [CNT_W-1:0]     w_cd_nxt;
  state_t               w_state_nxt;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_rise   = r_db & ~r_db_q;
  assign w_open   = (r_state == S_IDLE) || (r_state == S_ARMED);
  assign w_strike = w_open & enable & hammer_pulse;
  assign w_lit    = r_armed & mole_led;

`ifdef HAMMER_HIT_ONEHOT_EN
  assign w_sel = w_lit & (~w_lit + NUM_HOLES'(1));
`else
  assign w_sel = w_lit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        r_sync[s] <= '0;
    end else begin
      r_sync[0] <= swith;
      for (int s = 1; s < SYNC_STAGES; s++)
        r_sync[s] <= r_sync[s-1];
    end
  end

  // Debounced bit flips only after DB ticks of continuous disagreement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db   <= '0;
      r_db_q <= '0;
      for (int b = 0; b < NUM_HOLES; b++)
        r_db_cnt[b] <= '0;
    end else begin
      r_db_q <= r_db;
      for (int b = 0; b < NUM_HOLES; b++) begin
        if (w_synced[b] == r_db[b]) begin
          r_db_cnt[b] <= '0;
        end else if (r_db_cnt[b] == DB_LAST) begin
          r_db[b]     <= ~r_db[b];
          r_db_cnt[b] <= '0;
        end else begin
          r_db_cnt[b] <= r_db_cnt[b] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_armed_nxt = '0;
    if (enable && w_open && !w_strike)
      w_armed_nxt = (r_armed | (w_rise & mole_led)) & mole_led;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cd_nxt    = '0;
    case (r_state)
      S_IDLE, S_ARMED: begin
        if (w_strike)
          w_state_nxt = S_STRIKE;
        else if (|w_armed_nxt)
          w_state_nxt = S_ARMED;
        else
          w_state_nxt = S_IDLE;
      end
      S_STRIKE: w_state_nxt = S_COOL;
      S_COOL: begin
        if (r_cd_cnt == CD_LAST)
          w_state_nxt = S_IDLE;
        else
          w_cd_nxt = r_cd_cnt + CNT_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_cd_nxt    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cd_cnt <= '0;
      r_armed  <= '0;
      r_hit    <= '0;
      r_miss   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cd_cnt <= w_cd_nxt;
      r_armed  <= w_armed_nxt;
      r_hit    <= w_strike ? w_sel : '0;
      r_miss   <= w_strike & ~(|w_lit);
    end
  end

  assign hit_vec    = r_hit;
  assign miss_pulse = r_miss;
  assign armed      = r_armed;
  assign busy       = (r_state == S_STRIKE) || (r_state == S_COOL);

endmodule

// File: tb/tb_hammer_hit_detector.sv
// Bench for hammer_hit_detector: vector table, corner sequences,
// and randomized run against a history-based reference model.
module tb_hammer_hit_detector;

  localparam int N  = 5;
  localparam int S  = 2;
  localparam int TK = 4;
  localparam int CD = 8;

`ifdef HAMMER_HIT_ONEHOT_EN
  localparam logic [N-1:0] OH_EXP = 5'b00010;
`else
  localparam logic [N-1:0] OH_EXP = 5'b10010;
`endif

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [N-1:0] sw;
  logic [N-1:0] led;
  logic         ham;
  logic [N-1:0] hit_vec;
  logic         miss_pulse;
  logic [N-1:0] armed;
  logic         busy;

  int n_pass;
  int n_total;

  hammer_hit_detector #(
    .NUM_HOLES(N),
    .SYNC_STAGES(S),
    .SW_DEBOUNCE_TICKS(TK),
    .COOLDOWN_TICKS(CD),
    .CNT_W(25)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(en),
    .swith(sw),
    .mole_led(led),
    .hammer_pulse(ham),
    .hit_vec(hit_vec),
    .miss_pulse(miss_pulse),
    .armed(armed),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic [N-1:0] sw;
    logic [N-1:0] led;
    logic         ham;
    logic [N-1:0] hit;
    logic         miss;
    logic [N-1:0] arm;
    logic         busy;
  } vec_t;

  vec_t v [28];

  // reference model state: raw switch history and abstract status
  logic [N-1:0] hist [$];
  logic [N-1:0] m_db;
  logic [N-1:0] m_db_prev;
  logic [N-1:0] m_armed;
  logic [N-1:0] m_hit;
  logic         m_miss;
  int           m_busy;

  function automatic logic [11:0] pk(input logic [N-1:0] h,
                                     input logic m,
                                     input logic [N-1:0] a,
                                     input logic b);
    return {h, m, a, b};
  endfunction

  function automatic logic [N-1:0] pick(input logic [N-1:0] x);
    logic [N-1:0] r;
    r = '0;
`ifdef HAMMER_HIT_ONEHOT_EN
    for (int i = N - 1; i >= 0; i--)
      if (x[i]) begin
        r = '0;
        r[i] = 1'b1;
      end
`else
    r = x;
`endif
    return r;
  endfunction

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < S + TK; i++) hist.push_back('0);
    m_db = '0;
    m_db_prev = '0;
    m_armed = '0;
    m_hit = '0;
    m_miss = 1'b0;
    m_busy = 0;
  endfunction

  function automatic void model_step();
    logic [N-1:0] rise;
    logic [N-1:0] lit;
    logic [N-1:0] nd;
    logic         strike;
    logic         all_diff;
    int           sz;
    rise   = m_db & ~m_db_prev;
    strike = en && (m_busy == 0) && ham;
    lit    = m_armed & led;
    m_hit  = strike ? pick(lit) : '0;
    m_miss = strike && (lit == '0);
    if (!en || m_busy > 0 || strike) m_armed = '0;
    else m_armed = (m_armed | (rise & led)) & led;
    if (!en) m_busy = 0;
    else if (strike) m_busy = CD + 1;
    else if (m_busy > 0) m_busy--;
    nd = m_db;
    sz = hist.size();
    for (int b = 0; b < N; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < TK; j++)
        if (hist[sz - S - j][b] == m_db[b]) all_diff = 1'b0;
      if (all_diff) nd[b] = ~m_db[b];
    end
    m_db_prev = m_db;
    m_db = nd;
    hist.push_back(sw);
    if (hist.size() > S + TK) hist.delete(0);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string nm, input logic [11:0] act,
                     input logic [11:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else
      $display("FAIL %s: got hit=%b miss=%b armed=%b busy=%b want hit=%b miss=%b armed=%b busy=%b",
               nm, act[11:7], act[6], act[5:1], act[0],
               exp[11:7], exp[6], exp[5:1], exp[0]);
  endtask

  function automatic logic [11:0] dut_pk();
    return pk(hit_vec, miss_pulse, armed, busy);
  endfunction

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    en = 1'b0;
    sw = '0;
    led = '0;
    ham = 1'b0;
    model_reset();

    // basic hit on hole 2, then a strike on an unlit hole
    for (int i = 0; i < 28; i++)
      v[i] = '{1'b1, 5'b00100, 5'b00100, 1'b0, 5'b0, 1'b0, 5'b0, 1'b0};
    v[6].arm = 5'b00100;
    v[7].arm = 5'b00100;
    v[8].ham = 1'b1;
    v[8].hit = 5'b00100;
    for (int i = 8; i <= 16; i++) v[i].busy = 1'b1;
    for (int i = 19; i < 28; i++) begin
      v[i].sw = 5'b01100;
      v[i].led = 5'b00001;
    end
    v[26].ham = 1'b1;
    v[26].miss = 1'b1;
    v[26].busy = 1'b1;
    v[27].busy = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset", dut_pk(), pk('0, 1'b0, '0, 1'b0));
    rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      en = v[i].en;
      sw = v[i].sw;
      led = v[i].led;
      ham = v[i].ham;
      tick();
      chk($sformatf("vec%0d", i), dut_pk(),
          pk(v[i].hit, v[i].miss, v[i].arm, v[i].busy));
    end
    ham = 1'b0;

    // bounce on hole 1 never arms it
    sw = '0;
    led = 5'b00010;
    run(12);
    for (int c = 0; c < 20; c++) begin
      sw[1] = ((c / 2) % 2 == 0);
      tick();
    end
    sw = '0;
    run(8);
    chk("bounce_armed", dut_pk(), pk('0, 1'b0, '0, 1'b0));
    ham = 1'b1;
    tick();
    chk("bounce_miss", dut_pk(), pk('0, 1'b1, '0, 1'b1));
    ham = 1'b0;
    run(10);

    // LED goes dark after arming
    sw = 5'b10000;
    led = 5'b10000;
    run(8);
    chk("ledoff_armed", dut_pk(), pk('0, 1'b0, 5'b10000, 1'b0));
    led = '0;
    tick();
    chk("ledoff_clear", dut_pk(), pk('0, 1'b0, '0, 1'b0));
    ham = 1'b1;
    tick();
    chk("ledoff_miss", dut_pk(), pk('0, 1'b1, '0, 1'b1));
    ham = 1'b0;
    run(10);

    // rises and hammers inside cooldown are ignored
    ham = 1'b1;
    tick();
    ham = 1'b0;
    sw = 5'b10001;
    led = 5'b00001;
    run(2);
    ham = 1'b1;
    tick();
    chk("cool_ignore", dut_pk(), pk('0, 1'b0, '0, 1'b1));
    ham = 1'b0;
    run(8);
    chk("cool_after", dut_pk(), pk('0, 1'b0, '0, 1'b0));

    // async reset mid-cooldown
    ham = 1'b1;
    tick();
    ham = 1'b0;
    run(3);
    chk("pre_rst_busy", dut_pk(), pk('0, 1'b0, '0, 1'b1));
    rst_n = 1'b0;
    #1;
    chk("async_rst", dut_pk(), pk('0, 1'b0, '0, 1'b0));
    @(posedge clk);
    @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;

    // enable drop while armed
    sw = 5'b00110;
    led = 5'b00110;
    run(8);
    chk("en_armed", dut_pk(), pk('0, 1'b0, 5'b00110, 1'b0));
    en = 1'b0;
    tick();
    chk("en_drop", dut_pk(), pk('0, 1'b0, '0, 1'b0));
    ham = 1'b1;
    tick();
    chk("en_low_ham", dut_pk(), pk('0, 1'b0, '0, 1'b0));
    en = 1'b1;
    tick();
    chk("en_back_strike", dut_pk(), pk('0, 1'b1, '0, 1'b1));
    ham = 1'b0;
    run(10);

    // two armed lit holes on one press
    sw = '0;
    run(8);
    sw = 5'b10010;
    led = 5'b10010;
    run(8);
    chk("multi_armed", dut_pk(), pk('0, 1'b0, 5'b10010, 1'b0));
    ham = 1'b1;
    tick();
    chk("multi_hit", dut_pk(), pk(OH_EXP, 1'b0, '0, 1'b1));
    ham = 1'b0;
    run(10);

    // randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      en = ($urandom_range(15) != 0);
      for (int b = 0; b < N; b++)
        if ($urandom_range(9) == 0) sw[b] = ~sw[b];
      if ($urandom_range(19) == 0) led = N'($urandom);
      ham = ($urandom_range(11) == 0);
      tick();
      chk($sformatf("rand%0d", c), dut_pk(),
          pk(m_hit, m_miss, m_armed, m_busy > 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hammer_hit_detector.md
Name: hammer_hit_detector

Overview:
- Front end of the hammer path: turns raw hole switches, the lit-mole vector and the debounced hammer pulse into a one-cycle hit vector for the mole controller.
- Replaces the inline switch-edge logic in the top level.
- Adds switch synchronisation and debounce, per-hole arming, a strike FSM with post-strike cooldown, and a miss indication.
- Sits between the board switches / hammer debouncer and the mole LED/random controller's btn_hit_pulse input.

Parameters:
- NUM_HOLES, 5, number of holes/switches/LEDs.
- SYNC_STAGES, 2, synchroniser flops per switch; minimum 2.
- SW_DEBOUNCE_TICKS, 1_000_000, consecutive stable clk cycles before a debounced switch changes (10 ms @ 100 MHz).
- COOLDOWN_TICKS, 20_000_000, clk cycles during which the hammer is ignored after a strike (200 ms).
- CNT_W, 25, counter width; must hold max(SW_DEBOUNCE_TICKS, COOLDOWN_TICKS).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  game running (from FSM enable_mole_ctrl)
- swith  in  NUM_HOLES  raw asynchronous switches; bit i is under LED i
- mole_led  in  NUM_HOLES  currently lit moles
- hammer_pulse  in  1  one-cycle debounced hammer press
- hit_vec  out  NUM_HOLES  one-cycle hit vector to the mole controller
- miss_pulse  out  1  one-cycle: strike with no valid target
- armed  out  NUM_HOLES  per-hole armed flags (status/debug)
- busy  out  1  high in STRIKE or COOLDOWN

Behaviour:
- Reset (async, rst_n low): state IDLE; sync flops, debounced values, counters, armed, hit_vec and miss_pulse all 0; busy 0.
- Sync: each swith bit passes through SYNC_STAGES flops.
- Debounce (per bit):
  - Counter clears whenever the synced value equals the debounced value.
  - Otherwise it increments; when it reaches SW_DEBOUNCE_TICKS-1, the debounced value toggles and the counter clears.
  - Worst-case latency from raw edge is SYNC_STAGES + SW_DEBOUNCE_TICKS cycles.
- rise[i]: one cycle, on a debounced 0->1 transition. Falling edges are ignored.
- A switch held high through reset release produces one rise after debounce. This is intended.
- Arming, registered:
  - armed[i] <= 1 when rise[i] & mole_led[i] & enable, in IDLE or ARMED.
  - armed[i] <= 0 when mole_led[i]==0 or enable==0.
  - Clear has priority over set.
- States:
  - IDLE: armed==0.
  - ARMED: armed!=0.
  - STRIKE: one-cycle output state.
  - COOLDOWN: counts COOLDOWN_TICKS cycles.
- Transitions:
  - IDLE <-> ARMED follows armed!=0 on the next cycle.
  - IDLE/ARMED with hammer_pulse & enable -> STRIKE. On that edge:
    - hit_vec <= armed & mole_led.
    - miss_pulse <= ((armed & mole_led)==0).
    - armed <= 0.
    - A rise in the same cycle is discarded.
  - STRIKE -> COOLDOWN; hit_vec and miss_pulse return to 0.
  - COOLDOWN -> IDLE after COOLDOWN_TICKS cycles. Rises and hammer pulses in COOLDOWN are ignored; armed stays 0.
  - enable low in any state -> IDLE next cycle, counter cleared. A strike already registered still shows for its one cycle.
- Latency: hammer_pulse in cycle N -> hit_vec/miss_pulse high in cycle N+1 only.
- hit_vec and miss_pulse are never high together.
- hammer_pulse with enable low: no strike, no miss.
- Multiple armed lit holes: all reported in hit_vec (see optional feature).

Optional Feature:
- Macro: HAMMER_HIT_ONEHOT_EN.
- Defined: hit_vec carries only the lowest-index set bit of (armed & mole_led). One hammer press scores at most once.
- Undefined: hit_vec = armed & mole_led, so several holes can score on one press.
- miss_pulse behaviour is identical in both builds.

Test Plan:
- Sim parameters: SYNC_STAGES=2, SW_DEBOUNCE_TICKS=4, COOLDOWN_TICKS=8.
- Basic hit: enable=1, mole_led=00100, swith[2] 0->1 held, wait 8 cycles, hammer_pulse -> armed=00100 before the press; next cycle hit_vec=00100 for exactly 1 cycle; busy high 9 cycles; then IDLE.
- Miss/unlit: mole_led=00001, raise swith[3], hammer -> armed stays 0; miss_pulse=1 for 1 cycle; hit_vec=0.
- Bounce: toggle swith[1] every 2 cycles for 20 cycles, then hold 0 -> no rise, armed=0; a hammer gives miss only.
- LED off before strike: arm bit 4, drop mole_led[4] -> armed[4]=0 next cycle; hammer -> miss_pulse=1.
- Cooldown: strike, then raise swith[0] with mole_led=00001 and hammer at cycle +3 -> no hit, no miss, armed stays 0.
- Reset/enable: assert rst_n=0 mid-COOLDOWN -> all outputs 0 immediately. Drop enable while ARMED=00110 -> armed=0 and state IDLE next cycle.
- Onehot build: with HAMMER_HIT_ONEHOT_EN and armed & mole_led = 10010 -> hit_vec=00010. Without the macro -> 10010.
